// File: rtl/up_pkg.sv
// up_pkg: shared definitions for the accumulator microprocessor control unit.
//   - Opcode values found in IR[7:5]
//   - FSM state encoding, which is also the value on the State debug port
//   - Encodings of the datapath A-source select (Asel)
//   - op_to_state(): maps a decoded opcode to its execute state
package up_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_IN    = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_LOAD   = 4'd2,
        S_STORE  = 4'd3,
        S_ADD    = 4'd4,
        S_SUB    = 4'd5,
        S_INPUT  = 4'd6,
        S_JZ     = 4'd7,
        S_JPOS   = 4'd8,
        S_HALT   = 4'd9
    } state_e;

    localparam logic [1:0] ASEL_RES = 2'b00;  // adder/subtractor result
    localparam logic [1:0] ASEL_IN  = 2'b01;  // external Input bus
    localparam logic [1:0] ASEL_MEM = 2'b10;  // RAM data

    // Execute state reached from DECODE for a given opcode.
    function automatic state_e op_to_state(input logic [2:0] op);
        state_e st;
        case (op)
            OP_LOAD:  st = S_LOAD;
            OP_STORE: st = S_STORE;
            OP_ADD:   st = S_ADD;
            OP_SUB:   st = S_SUB;
            OP_IN:    st = S_INPUT;
            OP_JZ:    st = S_JZ;
            OP_JPOS:  st = S_JPOS;
            OP_HALT:  st = S_HALT;
            default:  st = S_FETCH;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/up_key_edge.sv
// up_key_edge: synchronises an asynchronous key and produces a one-cycle
// registered pulse for every rising edge seen after synchronisation.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset, clears all flops to 0
//   key_i   : raw asynchronous key level
//   pulse_o : one-cycle pulse per synchronised rising edge
// The pulse is registered so that consumers see a clean flop output.
module up_key_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   pulse_q;
    logic                   pulse_d;

    // Rising edge: synchronised level high while the history flop is still low.
    assign pulse_d = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Synchroniser chain, history flop and registered edge pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= {SYNC_STAGES{1'b0}};
            hist_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], key_i};
            hist_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/up_ctrl_fsm.sv
// up_ctrl_fsm: control unit of the 8-bit accumulator microprocessor.
// Sequences FETCH -> DECODE -> execute and drives every uP_DP control.
//   CLOCK  : system clock shared with the datapath
//   RESET  : asynchronous active-low reset
//   Enter  : raw user key, completes an IN instruction on its rising edge
//   IR     : opcode IR[7:5] from the datapath
//   Aeq0   : accumulator is zero        Apos : accumulator MSB is 0
//   IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub : datapath controls
//   Asel   : A source (00 result, 01 Input, 1x RAM)
//   Halt   : high in HALT               State : current state code
// Outputs are a decode of the state register. The only Mealy terms are in
// INPUT (registered edge pulse) and JZ/JPOS (Aeq0/Apos from the A register).
// All controls are additionally gated by RESET so they fall asynchronously
// and stay low while reset is held, even though the reset state is FETCH.
module up_ctrl_fsm
    import up_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       Enter,
    input  logic [7:5] IR,
    input  logic       Aeq0,
    input  logic       Apos,
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic       Aload,
    output logic       Sub,
    output logic [1:0] Asel,
    output logic       Halt,
    output logic [3:0] State
);

    state_e     state_q;
    state_e     state_d;
    logic       enter_p;

    logic       irload_s;
    logic       jmpmux_s;
    logic       pcload_s;
    logic       meminst_s;
    logic       memwr_s;
    logic       aload_s;
    logic       sub_s;
    logic [1:0] asel_s;
    logic       halt_s;

    up_key_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_key_edge (
        .clk_i   (CLOCK),
        .rst_ni  (RESET),
        .key_i   (Enter),
        .pulse_o (enter_p)
    );

    // Next-state selection.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = op_to_state(IR);
            S_LOAD,
            S_STORE,
            S_ADD,
            S_SUB,
            S_JZ,
            S_JPOS:   state_d = S_FETCH;
            S_INPUT: begin
                // Pulses that fired outside INPUT are gone; only a fresh edge completes.
                if (enter_p) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_INPUT;
                end
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;  // codes 10-15 recover to FETCH
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Control decode; anything not set for a state stays 0.
    always_comb begin
        irload_s  = 1'b0;
        jmpmux_s  = 1'b0;
        pcload_s  = 1'b0;
        meminst_s = 1'b0;
        memwr_s   = 1'b0;
        aload_s   = 1'b0;
        sub_s     = 1'b0;
        asel_s    = ASEL_RES;
        halt_s    = 1'b0;
        case (state_q)
            S_FETCH: begin
                irload_s = 1'b1;
                pcload_s = 1'b1;
            end
            S_DECODE: meminst_s = 1'b1;
            S_LOAD: begin
                meminst_s = 1'b1;
                aload_s   = 1'b1;
                asel_s    = ASEL_MEM;
            end
            S_STORE: begin
                meminst_s = 1'b1;
                memwr_s   = 1'b1;
            end
            S_ADD: begin
                meminst_s = 1'b1;
                aload_s   = 1'b1;
            end
            S_SUB: begin
                meminst_s = 1'b1;
                aload_s   = 1'b1;
                sub_s     = 1'b1;
            end
            S_INPUT: begin
                asel_s  = ASEL_IN;
                aload_s = enter_p;
            end
            S_JZ: begin
                if (Aeq0) begin
                    pcload_s = 1'b1;
                    jmpmux_s = 1'b1;
                end else begin
                    pcload_s = 1'b0;
                    jmpmux_s = 1'b0;
                end
            end
            S_JPOS: begin
                if (Apos) begin
                    pcload_s = 1'b1;
                    jmpmux_s = 1'b1;
                end else begin
                    pcload_s = 1'b0;
                    jmpmux_s = 1'b0;
                end
            end
            S_HALT:  halt_s = 1'b1;
            default: halt_s = 1'b0;  // illegal codes: everything 0
        endcase
    end

    assign IRload  = irload_s  & RESET;
    assign JMPmux  = jmpmux_s  & RESET;
    assign PCload  = pcload_s  & RESET;
    assign Meminst = meminst_s & RESET;
    assign MemWr   = memwr_s   & RESET;
    assign Aload   = aload_s   & RESET;
    assign Sub     = sub_s     & RESET;
    assign Asel    = asel_s    & {2{RESET}};
    assign Halt    = halt_s    & RESET;
    assign State   = state_q;

endmodule

// File: tb/tb_up_ctrl_fsm.sv
// tb_up_ctrl_fsm: directed, table-driven bench for up_ctrl_fsm.
// Control word layout used for comparisons:
//   {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel[1:0], Halt}
module tb_up_ctrl_fsm;

    localparam int SYNC = 2;

    localparam logic [9:0] C_NONE  = 10'b0000000000;
    localparam logic [9:0] C_FETCH = 10'b1010000000;
    localparam logic [9:0] C_DEC   = 10'b0001000000;
    localparam logic [9:0] C_LOAD  = 10'b0001010100;
    localparam logic [9:0] C_STORE = 10'b0001100000;
    localparam logic [9:0] C_ADD   = 10'b0001010000;
    localparam logic [9:0] C_SUB   = 10'b0001011000;
    localparam logic [9:0] C_JMP   = 10'b0110000000;
    localparam logic [9:0] C_INW   = 10'b0000000010;
    localparam logic [9:0] C_IN    = 10'b0000010010;
    localparam logic [9:0] C_HALT  = 10'b0000000001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enter;
    logic [2:0] ir;
    logic       aeq0;
    logic       apos;
    logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
    logic [1:0] Asel;
    logic [3:0] State;
    logic [9:0] ctl_w;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0] ir;
        logic       aeq0;
        logic       apos;
        logic [3:0] st;
        logic [9:0] ctl;
    } vec_t;

    vec_t vecs[10];

    up_ctrl_fsm #(.SYNC_STAGES(SYNC)) dut (
        .CLOCK   (clk),
        .RESET   (rst_n),
        .Enter   (enter),
        .IR      (ir),
        .Aeq0    (aeq0),
        .Apos    (apos),
        .IRload  (IRload),
        .JMPmux  (JMPmux),
        .PCload  (PCload),
        .Meminst (Meminst),
        .MemWr   (MemWr),
        .Aload   (Aload),
        .Sub     (Sub),
        .Asel    (Asel),
        .Halt    (Halt),
        .State   (State)
    );

    always #5 clk = ~clk;

    assign ctl_w = {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] es, input logic [9:0] ec);
        n_checks++;
        if (State !== es || ctl_w !== ec) begin
            n_errors++;
            $display("FAIL %s: got State=%0d ctl=%b, expected State=%0d ctl=%b",
                     tag, State, ctl_w, es, ec);
        end
    endtask

    // Wait (bounded) for the INPUT completion pulse and check its latency.
    task automatic wait_in_done(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (Aload === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_checks++;
        if (lat != exp_lat) begin
            n_errors++;
            $display("FAIL %s_latency: got %0d cycles, expected %0d (0 = timeout)",
                     tag, lat, exp_lat);
        end
        check({tag, "_pulse"}, 4'd6, C_IN);
        step();
        check({tag, "_next"}, 4'd0, C_FETCH);
    endtask

    initial begin
        vecs[0] = '{3'b000, 1'b0, 1'b0, 4'd2, C_LOAD};
        vecs[1] = '{3'b001, 1'b0, 1'b0, 4'd3, C_STORE};
        vecs[2] = '{3'b010, 1'b0, 1'b0, 4'd4, C_ADD};
        vecs[3] = '{3'b011, 1'b0, 1'b0, 4'd5, C_SUB};
        vecs[4] = '{3'b101, 1'b1, 1'b0, 4'd7, C_JMP};
        vecs[5] = '{3'b101, 1'b0, 1'b0, 4'd7, C_NONE};
        vecs[6] = '{3'b101, 1'b0, 1'b1, 4'd7, C_NONE};
        vecs[7] = '{3'b110, 1'b0, 1'b1, 4'd8, C_JMP};
        vecs[8] = '{3'b110, 1'b0, 1'b0, 4'd8, C_NONE};
        vecs[9] = '{3'b110, 1'b1, 1'b0, 4'd8, C_NONE};

        rst_n = 1'b0;
        enter = 1'b0;
        ir    = 3'b000;
        aeq0  = 1'b0;
        apos  = 1'b0;
        repeat (3) step();
        check("reset_held", 4'd0, C_NONE);
        rst_n = 1'b1;
        #1;
        check("reset_release", 4'd0, C_FETCH);

        // Three-cycle instructions, starting from FETCH each time.
        for (int v = 0; v < 10; v++) begin
            ir   = vecs[v].ir;
            aeq0 = vecs[v].aeq0;
            apos = vecs[v].apos;
            #1;
            check($sformatf("vec%0d_fetch", v), 4'd0, C_FETCH);
            step();
            check($sformatf("vec%0d_decode", v), 4'd1, C_DEC);
            step();
            check($sformatf("vec%0d_exec", v), vecs[v].st, vecs[v].ctl);
            step();
        end
        check("table_end_fetch", 4'd0, C_FETCH);
        aeq0 = 1'b0;
        apos = 1'b0;

        // STORE interrupted by reset: MemWr must fall without a clock edge.
        ir = 3'b001;
        step();
        step();
        check("store_exec", 4'd3, C_STORE);
        #2;
        rst_n = 1'b0;
        #1;
        check("store_async_reset", 4'd0, C_NONE);
        step();
        rst_n = 1'b1;
        #1;
        check("store_after_reset", 4'd0, C_FETCH);

        // IN: waits with Enter low, then completes SYNC+1 clocks after the rise.
        ir = 3'b100;
        step();
        step();
        check("in_enter", 4'd6, C_INW);
        for (int i = 0; i < 20; i++) begin
            step();
            check("in_wait_low", 4'd6, C_INW);
        end
        enter = 1'b1;
        wait_in_done("in_edge", SYNC + 1);

        // IN entered with Enter already high: needs a fresh rising edge.
        step();
        step();
        check("held_enter", 4'd6, C_INW);
        for (int i = 0; i < 10; i++) begin
            step();
            check("held_wait", 4'd6, C_INW);
        end
        enter = 1'b0;
        repeat (4) begin
            step();
            check("held_fall", 4'd6, C_INW);
        end
        enter = 1'b1;
        wait_in_done("held_reedge", SYNC + 1);

        // Edge while another instruction runs is discarded, not queued.
        enter = 1'b0;
        ir    = 3'b000;
        step();
        step();
        step();
        check("flush_fetch", 4'd0, C_FETCH);
        enter = 1'b1;
        step();
        check("early_decode", 4'd1, C_DEC);
        step();
        check("early_load", 4'd2, C_LOAD);
        step();
        check("early_fetch", 4'd0, C_FETCH);
        ir = 3'b100;
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            check("early_not_queued", 4'd6, C_INW);
        end
        enter = 1'b0;
        repeat (4) step();
        enter = 1'b1;
        wait_in_done("early_reedge", SYNC + 1);

        // HALT parks with all controls 0; Enter edges are ignored.
        ir = 3'b111;
        step();
        check("halt_decode", 4'd1, C_DEC);
        step();
        check("halt_enter", 4'd9, C_HALT);
        for (int i = 0; i < 50; i++) begin
            if (i % 5 == 0) begin
                enter = ~enter;
            end
            step();
            check("halt_hold", 4'd9, C_HALT);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("halt_reset", 4'd0, C_NONE);
        step();
        rst_n = 1'b1;
        #1;
        check("halt_release", 4'd0, C_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/up_ctrl_fsm.md
# up_ctrl_fsm

Control unit for the 8-bit accumulator microprocessor. It drives every control input of the `uP_DP` datapath and consumes that datapath's status outputs (`Aeq0`, `Apos`, `IR[7:5]`). It sequences fetch → decode → execute per instruction. It handles the `IN` instruction by waiting for a synchronised, edge-detected `Enter` key press, and parks in a halt state on `HALT`.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages in the `Enter` synchroniser (≥2).
- `CLOCK` input 1: system clock, shared with the datapath.
- `RESET` input 1: reset. One clock; reset is asynchronous and active-low.
- `Enter` input 1: raw, asynchronous user key; an `IN` instruction completes on its rising edge.
- `IR` input 3 (`[7:5]`): opcode from the datapath IR register.
- `Aeq0` input 1: accumulator == 0.
- `Apos` input 1: accumulator MSB == 0.
- `IRload`, `JMPmux`, `PCload`, `Meminst`, `MemWr`, `Aload`, `Sub` output 1 each: datapath controls.
- `Asel` output 2: A source. `00` = add/sub result, `01` = `Input`, `1x` = RAM data.
- `Halt` output 1: high while in HALT.
- `State` output 4: current state code, for debug/LEDs.

## Operation
- Opcodes (`IR[7:5]`): `000` LOAD, `001` STORE, `010` ADD, `011` SUB, `100` IN, `101` JZ, `110` JPOS, `111` HALT.
- State codes:
  - `0` FETCH, `1` DECODE, `2` LOAD, `3` STORE, `4` ADD, `5` SUB.
  - `6` INPUT, `7` JZ, `8` JPOS, `9` HALT.
  - Codes 10–15 are illegal and go to FETCH next cycle with all outputs 0.
- FETCH: `IRload=1`, `PCload=1`, `JMPmux=0`, `Meminst=0`; next state is DECODE.
- DECODE: `Meminst=1`, everything else 0; next state is selected by opcode (LOAD→2 … HALT→9).
- LOAD: `Meminst=1`, `Aload=1`, `Asel=10`; next FETCH.
- STORE: `Meminst=1`, `MemWr=1`; next FETCH.
- ADD: `Meminst=1`, `Aload=1`, `Asel=00`, `Sub=0`; next FETCH.
- SUB: same as ADD but `Sub=1`; next FETCH.
- INPUT: `Asel=01`. `Aload=1` only in the cycle the edge-detect pulse `enter_p` is 1, then next FETCH. Otherwise stay with `Aload=0`.
- JZ: if `Aeq0`, `PCload=1` and `JMPmux=1`. Next FETCH either way.
- JPOS: the same, conditioned on `Apos`.
- HALT: `Halt=1`, all controls 0. Stays until `RESET` is asserted.
- Outputs not listed for a state are 0. Mealy terms exist only in INPUT, JZ and JPOS, and depend only on registered signals: `enter_p`, and `Aeq0`/`Apos` from the A register.
- Enter path:
  - `SYNC_STAGES`-flop synchroniser, then one history flop.
  - `enter_p` = sync & ~history: a single-cycle pulse per rising edge.
  - Edges arriving outside INPUT are discarded, not queued.
  - A level held across a whole INPUT does not complete it; a fresh rising edge is required.

## Timing
- Reset:
  - While `RESET=0`, state=FETCH, synchroniser/history = 0, and every control output is forced 0 (`Halt=0`, `State=0`).
  - Release takes effect at the first `CLOCK` rise after deassertion.
  - Assertion mid-instruction (e.g. during STORE) drops `MemWr` immediately (asynchronously).
- Instruction latency:
  - 3 cycles for LOAD/STORE/ADD/SUB/JZ/JPOS.
  - INPUT: 3 cycles minimum. It completes in the cycle `enter_p` is high; `enter_p` rises `SYNC_STAGES`+1 clocks after the `Enter` rise is sampled.
  - HALT is entered 2 cycles after the FETCH of a `111` opcode.
- Taken jump: PC holds `IR[4:0]` after the JZ/JPOS edge; the following FETCH reads that address.
- Not-taken jump: PC keeps the incremented value.
- PC wrap at 31→0 is the datapath's concern; this block is unaffected.

## Structure
- Package `up_pkg`: opcode localparams (`OP_LOAD` … `OP_HALT`), state enum/codes (`S_FETCH` … `S_HALT`), `Asel` encodings (`ASEL_RES`, `ASEL_IN`, `ASEL_MEM`).
- Sub-module `up_key_edge`: parameterised synchroniser + rising-edge pulse, reset to 0.
- Top: state register (async active-low clear), next-state logic, output decode.
- Estimated 150–250 lines total.

## Test plan
- Reset released, `IR=000`: `State` goes 0→1→2→0. `IRload=PCload=1` in cycle 0; `Aload=1`, `Asel=10`, `Meminst=1` in cycle 2.
- `IR=001` (STORE): `MemWr=1` for exactly one cycle (state 3). `RESET` pulsed low within that cycle → `MemWr` drops at once and `State=0`.
- `IR=101`:
  - `Aeq0=1` → `PCload=JMPmux=1` in state 7.
  - Repeat with `Aeq0=0` → both stay 0.
  - Same check for `IR=110` with `Apos`.
- `IR=100`, `Enter` held low for 20 cycles → state stays 6 with `Aload=0`. `Enter` rises → exactly one cycle of `Aload=1`, `Asel=01`, `SYNC_STAGES`+1 clocks after sampling, then `State=0`.
- `Enter` already high when INPUT is entered → no completion until `Enter` falls and rises again. An edge during FETCH/DECODE is ignored.
- `IR=111` → `Halt=1`, `State=9` held for 50 cycles with all controls 0. Further `Enter` edges have no effect. `RESET` low → `Halt=0`, `State=0`.
